// File: rtl/uart_pkg.sv
// uart_pkg
//  Shared definitions for the UART receive and transmit paths.
//  - UART_DATA_WIDTH : default payload width of a frame
//  - PAR_EVEN/PAR_ODD: Parity_Type encodings (shared with the transmitter)
//  - rx_state_e      : receive FSM state encoding
//  - majority3       : 2-of-3 vote used by the bit sampler
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//  Bit-period timing and centre sampling for the UART receiver.
//  Ports:
//    CLK, RST      clock, asynchronous active-low reset
//    run           high while a frame is in progress; edge_cnt is held at 0 otherwise
//    rx_in         synchronised serial line
//    prescale      oversampling ratio latched by the FSM at frame start
//    sampled_bit   2-of-3 majority of the three centre taps
//    sample_valid  one-cycle strobe once all three taps of this bit are captured
//    end_of_bit    high on the last cycle of the bit period (edge_cnt = P-1)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  end_of_bit
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic [2:0]            taps;

  assign half      = prescale >> 1;
  assign last_edge = prescale - ONE;

  // ">=" rather than "==" so an illegal prescale can never strand the counter
  // past its wrap point; prescale = 0 simply gives a 2^PRESCALE_W-cycle bit.
  assign end_of_bit   = run && (edge_cnt >= last_edge);
  assign sample_valid = run && (edge_cnt == half + TWO);
  assign sampled_bit  = majority3(taps);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
    end else if (!run || end_of_bit) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + ONE;
    end
  end

  // Three taps straddling the bit centre: P/2-1, P/2, P/2+1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      taps <= '0;
    end else if (run) begin
      if (edge_cnt == half - ONE) taps[0] <= rx_in;
      if (edge_cnt == half)       taps[1] <= rx_in;
      if (edge_cnt == half + ONE) taps[2] <= rx_in;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//  UART receive engine: start-bit detection, LSB-first deserialisation,
//  optional parity check, stop-bit check and a one-cycle Data_Valid strobe.
//  Ports:
//    CLK, RST       clock (Prescale x baud), asynchronous active-low reset
//    RX_IN          synchronised serial line, idles high
//    Prescale       oversampling ratio (8/16/32), latched at start detection
//    Parity_Enable  frame carries a parity bit after the data
//    Parity_Type    PAR_EVEN / PAR_ODD
//    P_DATA         last error-free byte
//    Data_Valid     one-cycle pulse when P_DATA is updated
//    Parity_Error   parity mismatch in the last frame
//    Stop_Error     stop bit sampled low in the last frame
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_e state, next_state;

  logic [PRESCALE_W-1:0] prescale_q;
  logic                  pe_q;
  logic                  pt_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  bit_q;
  logic                  par_flag;
  logic                  expected_par;

  logic sampled_bit;
  logic sample_valid;
  logic end_of_bit;

  logic load_cfg;
  logic shift_en;
  logic par_check;
  logic frame_end;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .run          (state != RX_IDLE),
    .rx_in        (RX_IN),
    .prescale     (prescale_q),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .end_of_bit   (end_of_bit)
  );

  assign expected_par = (pt_q == PAR_ODD) ? ~^shift_reg : ^shift_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= RX_IDLE;
    else      state <= next_state;
  end

  // Every decision after IDLE waits for the end of the bit period, by which
  // time bit_q holds the voted value of the current bit.
  always_comb begin
    next_state = state;
    load_cfg   = 1'b0;
    shift_en   = 1'b0;
    par_check  = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (!RX_IN) begin
          next_state = RX_START;
          load_cfg   = 1'b1;
        end
      end
      RX_START: begin
        if (end_of_bit) next_state = bit_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (end_of_bit) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = pe_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (end_of_bit) begin
          par_check  = 1'b1;
          next_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (end_of_bit) begin
          frame_end  = 1'b1;
          next_state = RX_IDLE;
        end
      end
      default: next_state = RX_IDLE;
    endcase
  end

  // Voted bit value, held from the valid strobe to the end of the bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              bit_q <= 1'b1;
    else if (sample_valid) bit_q <= sampled_bit;
  end

  // Frame configuration is frozen at start detection so mid-frame changes
  // on the control inputs cannot corrupt a frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q <= '0;
      pe_q       <= 1'b0;
      pt_q       <= PAR_EVEN;
    end else if (load_cfg) begin
      prescale_q <= Prescale;
      pe_q       <= Parity_Enable;
      pt_q       <= Parity_Type;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (load_cfg) begin
      bit_cnt   <= '0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + BCW'(1);
      shift_reg <= {bit_q, shift_reg[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           par_flag <= 1'b0;
    else if (load_cfg)  par_flag <= 1'b0;
    else if (par_check) par_flag <= (bit_q != expected_par);
  end

  // Errors are cleared when a new start is detected and updated together at
  // the end of the stop bit; P_DATA only moves for a clean frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      if (load_cfg) begin
        Parity_Error <= 1'b0;
        Stop_Error   <= 1'b0;
      end else if (frame_end) begin
        Parity_Error <= par_flag;
        Stop_Error   <= ~bit_q;
        if (!par_flag && bit_q) begin
          P_DATA     <= shift_reg;
          Data_Valid <= 1'b1;
        end
      end
    end
  end

endmodule
